muldiv_unit: RTL

//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of the HI/LO register pair.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_div_step.sv | 27 ++
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and helpers for the HI/LO multiply/divide unit.
// Pure declarations: no latency, no backpressure.
package muldiv_pkg;

  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } muldiv_state_t;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration on unsigned magnitudes; purely combinational.
// Zero latency, no backpressure: the caller registers rem/quo every cycle.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {1'b0, divisor_i};
    // rem stays below divisor, so a non-negative diff always fits in 32 bits
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; multiply MUL_CYCLES cycles, divide 33 cycles.
// busy stalls the issuing stage combinationally from the start cycle until the cycle after done.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CNT_W = (MUL_CYCLES > 32) ? $clog2(MUL_CYCLES) : 5;

  muldiv_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [31:0] step_rem, step_quo;

  logic signed [32:0] mul_a_ext, mul_b_ext;
  logic signed [63:0] prod_c;
  logic [63:0]        prod_w;

  // Sign/zero extension to 33 bits makes one signed multiply serve both MULT and MULTU
  assign mul_a_ext = {sgn_q & a_q[31], a_q};
  assign mul_b_ext = {sgn_q & b_q[31], b_q};
  assign prod_c    = 64'(mul_a_ext) * 64'(mul_b_ext);

  generate
    if (MUL_CYCLES == 1) begin : g_no_pipe
      assign prod_w = prod_c;
    end else begin : g_pipe
      logic [63:0] stage_q [MUL_CYCLES-1];
      always_ff @(posedge clk_i) begin
        stage_q[0] <= prod_c;
        for (int i = 1; i < MUL_CYCLES - 1; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
      assign prod_w = stage_q[MUL_CYCLES-2];
    end
  endgenerate

  div_step u_div_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  assign busy_o = start_i | (state_q != IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    done_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (op_i == OP_MULT || op_i == OP_MULTU) begin
            state_d = MUL;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
            a_d     = a_i;
            b_d     = b_i;
            sgn_d   = (op_i == OP_MULT);
          end else if (op_i == OP_DIV || op_i == OP_DIVU) begin
            state_d = DIV;
            cnt_d   = CNT_W'(DIV_STEPS - 1);
            a_d     = a_i;
            b_d     = b_i;
            sgn_d   = (op_i == OP_DIV);
            rem_d   = '0;
            quo_d   = mag32(a_i, op_i == OP_DIV);
            dvs_d   = mag32(b_i, op_i == OP_DIV);
          end
        end else begin
          if (hi_we_i) hi_d = wdata_i;
          if (lo_we_i) lo_d = wdata_i;
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = prod_w;
          done_o       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        // Divide by zero leaves the raw dividend in HI and all-ones in LO, no trap
        if (dvs_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = (sgn_q && (a_q[31] ^ b_q[31])) ? (~quo_q + 32'd1) : quo_q;
          hi_d = (sgn_q && a_q[31]) ? (~rem_q + 32'd1) : rem_q;
        end
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i || reset_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

endmodule
